cordic_scheduler: RTL

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

---
 rtl/cordic_sched_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/cordic_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the CORDIC job scheduler.
package cordic_sched_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, and when both
// request the pointer selects the winner. The grant is one-hot or zero.
module rr_arbiter_2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // Resolve contention with the pointer; otherwise pass the single request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC core between two requesters. A job is accepted in IDLE,
// launched with a one-cycle start strobe, awaited in WAIT and presented for one
// cycle in OUTPUT; the round-robin pointer then favours the other requester.
// Optional watchdog: define CORDIC_SCHED_TIMEOUT_EN to abandon jobs whose core
// never reports done within TIMEOUT_CYCLES cycles of WAIT.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic [DATA_WIDTH-1:0] req0_z_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [DATA_WIDTH-1:0] req1_z_i,
  output logic                  req1_ready_o,
  output logic                  core_start_o,
  output logic [DATA_WIDTH-1:0] core_z_o,
  input  logic [DATA_WIDTH-1:0] core_x_i,
  input  logic [DATA_WIDTH-1:0] core_y_i,
  input  logic                  core_done_i,
  output logic [DATA_WIDTH-1:0] res_x_o,
  output logic [DATA_WIDTH-1:0] res_y_o,
  output logic                  res_id_o,
  output logic                  res_valid_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  sched_state_e          state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] core_z_q, core_z_d;
  logic [DATA_WIDTH-1:0] res_x_q, res_x_d;
  logic [DATA_WIDTH-1:0] res_y_q, res_y_d;
  logic                  res_id_q, res_id_d;
  logic [1:0]            grant;
  logic                  timeout_hit;

  rr_arbiter_2 u_arb (
    .valid_i ({req1_valid_i, req0_valid_i}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Fires on the cycle after TIMEOUT_CYCLES full WAIT cycles have passed.
  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  // Watchdog absent: WAIT only ends on core_done_i.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and datapath capture for the job lifecycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    core_z_d = core_z_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;
    res_id_d = res_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          core_z_d = grant[1] ? req1_z_i : req0_z_i;
          res_id_d = grant[1];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timeout_hit) begin
          ptr_d   = ~res_id_q;
          state_d = ST_IDLE;
        end else if (core_done_i) begin
          res_x_d = core_x_i;
          res_y_d = core_y_i;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        ptr_d   = ~res_id_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      core_z_q <= '0;
      res_x_q  <= '0;
      res_y_q  <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      core_z_q <= core_z_d;
      res_x_q  <= res_x_d;
      res_y_q  <= res_y_d;
      res_id_q <= res_id_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req0_ready_o = grant[0] && (state_q == ST_IDLE) && !rst_i;
  assign req1_ready_o = grant[1] && (state_q == ST_IDLE) && !rst_i;
  assign core_start_o = (state_q == ST_ISSUE);
  assign core_z_o     = core_z_q;
  assign res_x_o      = res_x_q;
  assign res_y_o      = res_y_q;
  assign res_id_o     = res_id_q;
  assign res_valid_o  = (state_q == ST_OUTPUT);
  assign busy_o       = (state_q != ST_IDLE);
  assign timeout_o    = timeout_hit;

endmodule
